scarv_cop_malu_wb: RTL and testbench

SCARV_COP_MALU_WB -- requirements
Module: scarv_cop_malu_wb

---
 rtl/scarv_cop_common_pkg.sv | 25 ++
 rtl/scarv_cop_wb_fifo.sv | 79 +++++++
 rtl/scarv_cop_malu_wb.sv | 143 ++++++++++++++
 tb/tb_scarv_cop_malu_wb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_common_pkg.sv
// ---------------------------------------------------------------------------
// scarv_cop_common
//   Shared definitions for the coprocessor writeback path.
//   - SCARV_COP_WB_DEPTH   : default number of writeback buffer entries.
//   - SCARV_COP_WB_ENTRY_W : width of one buffered write (addr + ben + data).
//   - wb_entry_t           : packed layout of a buffered write.
//   - wb_addr()            : forms a CPR address from a register pair and word index.
// ---------------------------------------------------------------------------
package scarv_cop_common;

    localparam int SCARV_COP_WB_DEPTH   = 2;
    localparam int SCARV_COP_WB_ENTRY_W = 40;

    typedef struct packed {
        logic [3:0]  addr;
        logic [3:0]  ben;
        logic [31:0] data;
    } wb_entry_t;

    // Register pair rdm maps to CPRs {rdm,0} (lo) and {rdm,1} (hi).
    function automatic logic [3:0] wb_addr(input logic [2:0] rdm, input logic widx);
        return {rdm, widx};
    endfunction

endpackage

// File: rtl/scarv_cop_wb_fifo.sv
// ---------------------------------------------------------------------------
// scarv_cop_wb_fifo
//   Small FIFO holding pending coprocessor register writes.
//   Ports:
//     g_clk, g_reset   clock and asynchronous active-high reset
//     push, push_data  enqueue request and entry (ignored when full)
//     pop              dequeue request (ignored when empty)
//     full, empty      occupancy flags
//     almost_full      exactly one free slot remains
//     head             oldest entry, forced to zero when empty
//   Storage is not reset; the head output is masked instead.
// ---------------------------------------------------------------------------
module scarv_cop_wb_fifo
    import scarv_cop_common::*;
#(
    parameter int DEPTH = SCARV_COP_WB_DEPTH,
    parameter int WIDTH = SCARV_COP_WB_ENTRY_W
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic push_ok;
    logic pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg == CW'(DEPTH - 1));
    assign head        = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/scarv_cop_malu_wb.sv
// ---------------------------------------------------------------------------
// scarv_cop_malu_wb
//   Buffers MALU register writes and drains them to the CPR write port when
//   the port is granted.
//   Ports:
//     g_clk, g_reset        clock and asynchronous active-high reset
//     malu_wen/ben/wdata    MALU write request, byte enables, data
//     malu_idone            MALU instruction completes this cycle
//     id_rdm                destination register pair
//     malu_hold             stall request back to MALU issue
//     cpr_wen/waddr/ben/wdata  head-of-buffer write request to the CPRs
//     cpr_wgnt              CPR write port granted this cycle
//     wb_pend               per-CPR "write still buffered" mask
//     wb_ovf                sticky: write attempted while buffer full
// ---------------------------------------------------------------------------
module scarv_cop_malu_wb
    import scarv_cop_common::*;
#(
    parameter int DEPTH = SCARV_COP_WB_DEPTH
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        malu_wen,
    input  logic [3:0]  malu_ben,
    input  logic [31:0] malu_wdata,
    input  logic        malu_idone,
    input  logic [2:0]  id_rdm,
    output logic        malu_hold,
    output logic        cpr_wen,
    output logic [3:0]  cpr_waddr,
    output logic [3:0]  cpr_ben,
    output logic [31:0] cpr_wdata,
    input  logic        cpr_wgnt,
    output logic [15:0] wb_pend,
    output logic        wb_ovf
);

    localparam int CW = $clog2(DEPTH + 1);

    logic      widx_reg;
    logic      widx_next;
    logic      ovf_reg;

    logic      full;
    logic      empty;
    logic      almost_full;
    logic      push;
    logic      pop;
    logic      ovf_try;
    wb_entry_t push_entry;
    wb_entry_t head_entry;
    logic [SCARV_COP_WB_ENTRY_W-1:0] head_bits;

    // A write with no byte enables carries nothing and is dropped outright.
    assign push    = malu_wen && (malu_ben != 4'b0000) && !full;
    assign pop     = cpr_wgnt && !empty;
    assign ovf_try = malu_wen && full;

    assign push_entry.addr = wb_addr(id_rdm, widx_reg);
    assign push_entry.ben  = malu_ben;
    assign push_entry.data = malu_wdata;

    // A rejected (overflowing) write leaves widx alone so the retried write
    // lands on the same half of the pair.
    always_comb begin
        widx_next = widx_reg;
        if (ovf_try) begin
            widx_next = widx_reg;
        end else if (push) begin
            widx_next = malu_idone ? 1'b0 : ~widx_reg;
        end else if (malu_idone) begin
            widx_next = 1'b0;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            widx_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            widx_reg <= widx_next;
            if (ovf_try) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    scarv_cop_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SCARV_COP_WB_ENTRY_W)
    ) u_fifo (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .push        (push),
        .push_data   (push_entry),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .head        (head_bits)
    );

    assign head_entry = head_bits;

    // Head is already zero-masked by the FIFO when empty.
    assign cpr_wen   = !empty;
    assign cpr_waddr = head_entry.addr;
    assign cpr_ben   = head_entry.ben;
    assign cpr_wdata = head_entry.data;

    // Hold one cycle early: with a single free slot and no drain this cycle,
    // the next issued write would find the buffer full.
    assign malu_hold = full || (almost_full && !pop);

    assign wb_ovf = ovf_reg;

    // Per-register count of buffered writes; the pending bit is "count != 0",
    // so a simultaneous push and pop of the same register keeps it set.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pend
            logic [CW-1:0] cnt_reg;
            logic          inc;
            logic          dec;

            assign inc = push && (push_entry.addr == 4'(gi));
            assign dec = pop && (head_entry.addr == 4'(gi));

            always_ff @(posedge g_clk or posedge g_reset) begin
                if (g_reset) begin
                    cnt_reg <= '0;
                end else if (inc && !dec) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end else if (dec && !inc) begin
                    cnt_reg <= cnt_reg - CW'(1);
                end
            end

            assign wb_pend[gi] = (cnt_reg != '0);
        end
    endgenerate

endmodule

// File: tb/tb_scarv_cop_malu_wb.sv
// ---------------------------------------------------------------------------
// tb_scarv_cop_malu_wb
//   Self-checking bench: a queue-based model of the writeback buffer is
//   compared with the DUT on every falling edge, plus directed scenarios with
//   hand-computed expectations and a randomized phase.
// ---------------------------------------------------------------------------
module tb_scarv_cop_malu_wb;
    import scarv_cop_common::*;

    localparam int DEPTH = 2;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        malu_wen;
    logic [3:0]  malu_ben;
    logic [31:0] malu_wdata;
    logic        malu_idone;
    logic [2:0]  id_rdm;
    logic        malu_hold;
    logic        cpr_wen;
    logic [3:0]  cpr_waddr;
    logic [3:0]  cpr_ben;
    logic [31:0] cpr_wdata;
    logic        cpr_wgnt;
    logic [15:0] wb_pend;
    logic        wb_ovf;

    always #5 g_clk = ~g_clk;

    scarv_cop_malu_wb #(.DEPTH(DEPTH)) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .malu_wen   (malu_wen),
        .malu_ben   (malu_ben),
        .malu_wdata (malu_wdata),
        .malu_idone (malu_idone),
        .id_rdm     (id_rdm),
        .malu_hold  (malu_hold),
        .cpr_wen    (cpr_wen),
        .cpr_waddr  (cpr_waddr),
        .cpr_ben    (cpr_ben),
        .cpr_wdata  (cpr_wdata),
        .cpr_wgnt   (cpr_wgnt),
        .wb_pend    (wb_pend),
        .wb_ovf     (wb_ovf)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of pending writes plus per-register counts.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  ben;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   pend_cnt[16];
    bit   m_widx;
    bit   m_ovf;

    always @(posedge g_clk or posedge g_reset) begin : model
        bit   m_full;
        bit   m_pop;
        bit   m_push;
        ent_t e;
        ent_t h;
        if (g_reset) begin
            mq.delete();
            m_widx = 0;
            m_ovf  = 0;
            for (int i = 0; i < 16; i++) pend_cnt[i] = 0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = cpr_wgnt && (mq.size() != 0);
            m_push = malu_wen && (malu_ben != 4'd0) && !m_full;
            e.addr = {id_rdm, m_widx};
            e.ben  = malu_ben;
            e.data = malu_wdata;
            if (malu_wen && m_full)  m_ovf = 1;
            else if (m_push)         m_widx = malu_idone ? 1'b0 : ~m_widx;
            else if (malu_idone)     m_widx = 0;
            if (m_pop) begin
                h = mq.pop_front();
                pend_cnt[h.addr]--;
            end
            if (m_push) begin
                mq.push_back(e);
                pend_cnt[e.addr]++;
            end
        end
    end

    // Compare process: outputs versus model, away from the active edge.
    always @(negedge g_clk) begin : compare
        int          sz;
        logic        exp_hold;
        logic [15:0] exp_pend;
        if (cmp_en && !g_reset) begin
            sz       = mq.size();
            exp_hold = (sz == DEPTH) || ((sz == DEPTH - 1) && !(cpr_wgnt && sz != 0));
            for (int r = 0; r < 16; r++) exp_pend[r] = (pend_cnt[r] != 0);
            check("cmp_cpr_wen",   cpr_wen,   sz != 0);
            check("cmp_cpr_waddr", cpr_waddr, (sz != 0) ? mq[0].addr : 4'd0);
            check("cmp_cpr_ben",   cpr_ben,   (sz != 0) ? mq[0].ben  : 4'd0);
            check("cmp_cpr_wdata", cpr_wdata, (sz != 0) ? mq[0].data : 32'd0);
            check("cmp_malu_hold", malu_hold, exp_hold);
            check("cmp_wb_pend",   wb_pend,   exp_pend);
            check("cmp_wb_ovf",    wb_ovf,    m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic wen, input logic [3:0] ben, input logic [31:0] data,
                         input logic idone, input logic [2:0] rdm, input logic gnt);
        malu_wen   = wen;
        malu_ben   = ben;
        malu_wdata = data;
        malu_idone = idone;
        id_rdm     = rdm;
        cpr_wgnt   = gnt;
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    logic [35:0] got[$];
    logic [35:0] exp039[4];
    logic [31:0] wd039[4];

    initial begin
        int n;
        g_reset = 1'b1;
        drive(0, 4'd0, 32'd0, 0, 3'd0, 1);
        cmp_en = 1;
        repeat (2) @(posedge g_clk);
        #1;
        check("reset_cpr_wen",   cpr_wen,   0);
        check("reset_cpr_waddr", cpr_waddr, 0);
        check("reset_cpr_wdata", cpr_wdata, 0);
        check("reset_wb_pend",   wb_pend,   0);
        check("reset_wb_ovf",    wb_ovf,    0);
        check("reset_malu_hold", malu_hold, 0);
        @(negedge g_clk);
        g_reset = 1'b0;
        tick();

        // Two-write instruction on pair 3.
        $display("txn two_write rdm=3");
        drive(1, 4'hF, 32'hAAAA_0001, 0, 3'd3, 1); tick();
        check("t2w_addr_a", cpr_waddr, 6);
        check("t2w_data_a", cpr_wdata, 32'hAAAA_0001);
        drive(1, 4'hF, 32'hBBBB_0002, 1, 3'd3, 1); tick();
        check("t2w_addr_b", cpr_waddr, 7);
        check("t2w_data_b", cpr_wdata, 32'hBBBB_0002);
        drive(1, 4'hF, 32'hCCCC_0003, 1, 3'd3, 1); tick();
        check("t2w_widx_back_to_lo", cpr_waddr, 6);
        drive(0, 4'd0, 32'd0, 0, 3'd0, 1); tick();
        check("t2w_drained", cpr_wen, 0);

        // Single-write instruction to c10.
        $display("txn single_write rdm=5");
        drive(1, 4'hF, 32'h0000_0001, 1, 3'd5, 1); tick();
        check("t1w_wen",  cpr_wen,   1);
        check("t1w_addr", cpr_waddr, 10);
        check("t1w_data", cpr_wdata, 32'h0000_0001);
        drive(0, 4'd0, 32'd0, 0, 3'd0, 1); tick();
        check("t1w_drained", cpr_wen, 0);

        // Grant blocked for 4 cycles across two two-write instructions.
        $display("txn grant_blocked");
        wd039  = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
        exp039 = '{{4'd2, 32'h1111_0000}, {4'd3, 32'h2222_0000},
                   {4'd4, 32'h3333_0000}, {4'd5, 32'h4444_0000}};
        got.delete();
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            cpr_wgnt = (cyc >= 4);
            #1;
            if (cyc == 1) check("tgb_hold_after_1_push", malu_hold, 1);
            if (cpr_wen && cpr_wgnt) got.push_back({cpr_waddr, cpr_wdata});
            if (!malu_hold && n < 4) begin
                drive(1, 4'hF, wd039[n], (n % 2) == 1, (n < 2) ? 3'd1 : 3'd2, cpr_wgnt);
                n++;
            end else begin
                drive(0, 4'd0, 32'd0, 0, 3'd0, cpr_wgnt);
            end
            tick();
        end
        check("tgb_drain_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check($sformatf("tgb_drain_%0d", i), got[i], exp039[i]);

        // Overflow: third write forced while full.
        $display("txn overflow");
        drive(1, 4'hF, 32'h5555_000A, 0, 3'd6, 0); tick();
        drive(1, 4'hF, 32'h5555_000B, 0, 3'd6, 0); tick();
        check("tovf_hold_full", malu_hold, 1);
        check("tovf_not_yet",   wb_ovf,    0);
        drive(1, 4'hF, 32'h5555_000C, 0, 3'd6, 0); tick();
        check("tovf_set",       wb_ovf,    1);
        check("tovf_head_addr", cpr_waddr, 12);
        check("tovf_head_data", cpr_wdata, 32'h5555_000A);
        drive(0, 4'd0, 32'd0, 1, 3'd0, 0); tick();
        drive(0, 4'd0, 32'd0, 0, 3'd0, 1); tick();
        check("tovf_second_addr", cpr_waddr, 13);
        check("tovf_second_data", cpr_wdata, 32'h5555_000B);
        tick();
        check("tovf_drained", cpr_wen, 0);
        check("tovf_sticky",  wb_ovf,  1);

        // Pending mask on c4.
        $display("txn pending_mask");
        drive(1, 4'hF, 32'h0404_0001, 1, 3'd2, 0); tick();
        drive(1, 4'hF, 32'h0404_0002, 1, 3'd2, 0); tick();
        check("tpend_set", wb_pend[4], 1);
        drive(0, 4'd0, 32'd0, 0, 3'd0, 1); tick();
        check("tpend_after_one_pop", wb_pend[4], 1);
        check("tpend_head_data",     cpr_wdata,  32'h0404_0002);
        tick();
        check("tpend_clear", wb_pend, 0);

        // Asynchronous reset mid-drain.
        $display("txn reset_mid_drain");
        drive(1, 4'hF, 32'h7777_0001, 0, 3'd7, 0); tick();
        drive(1, 4'hF, 32'h7777_0002, 0, 3'd7, 0); tick();
        drive(0, 4'd0, 32'd0, 0, 3'd0, 1); tick();
        check("trst_pre_wen", cpr_wen, 1);
        #2;
        g_reset = 1'b1;
        #1;
        check("trst_wen_now",  cpr_wen,   0);
        check("trst_pend_now", wb_pend,   0);
        check("trst_ovf_now",  wb_ovf,    0);
        check("trst_hold_now", malu_hold, 0);
        @(negedge g_clk);
        #1;
        g_reset = 1'b0;
        tick();
        drive(1, 4'hF, 32'h7777_0003, 0, 3'd7, 1); tick();
        check("trst_next_lo_addr", cpr_waddr, 14);
        check("trst_next_lo_data", cpr_wdata, 32'h7777_0003);
        drive(0, 4'd0, 32'd0, 1, 3'd0, 1); tick();

        // Randomized traffic against the model.
        $display("txn random_phase");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       w;
            logic [3:0] b;
            if (cyc == 1500) begin
                g_reset = 1'b1;
                @(negedge g_clk);
                #1;
                g_reset = 1'b0;
                tick();
            end
            cpr_wgnt = ($urandom_range(0, 3) != 0);
            #1;
            w = ($urandom_range(0, 2) != 0);
            b = 4'd0;
            if (w) b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if (malu_hold && $urandom_range(0, 9) != 0) begin
                w = 1'b0;
                b = 4'd0;
            end
            drive(w, b, $urandom, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), cpr_wgnt);
            tick();
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
